// File: rtl/instr_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Bundles the instruction ROM port, the pipeline control inputs and the
// fetched-instruction outputs of instr_fetch_unit into one interface.
//
// Signals:
//   rom_addr       address presented to the ROM (driven by the fetch unit)
//   rom_data       word returned combinationally by the ROM
//   stall          hold all fetch state for this cycle
//   redirect_valid branch taken in execute
//   redirect_pc    branch target
//   instr          registered fetched instruction
//   instr_pc       address instr was fetched from
//   instr_valid    instr is valid for decode this cycle
//   halted         halt word fetched, fetch frozen
//   fetch_count    count of normal fetches (only with IFU_FETCH_COUNT_EN)
//
// Modports:
//   master  fetch unit side (initiator of ROM reads)
//   slave   ROM / pipeline side
//
// Optional feature macro: IFU_FETCH_COUNT_EN
// ---------------------------------------------------------------------------
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 10,
    parameter int INSTR_W = 10
);
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;
    logic               instr_valid;
    logic               halted;
`ifdef IFU_FETCH_COUNT_EN
    logic [15:0]        fetch_count;
`endif

    modport master (
        output rom_addr,
        input  rom_data,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output instr,
        output instr_pc,
        output instr_valid,
`ifdef IFU_FETCH_COUNT_EN
        output fetch_count,
`endif
        output halted
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  instr,
        input  instr_pc,
        input  instr_valid,
`ifdef IFU_FETCH_COUNT_EN
        input  fetch_count,
`endif
        input  halted
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//
// Initiator side of the instruction ROM interface. Owns the program counter,
// drives the ROM address, and registers the returned word for decode.
// Direct jumps (opcode JUMP_OP in instr[9:6]) are folded locally, branch
// redirects from execute are accepted, and the halt word freezes fetch until
// reset.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high reset
//   bus    instr_fetch_unit_if.master (ROM port, stall/redirect inputs,
//          instr/instr_pc/instr_valid/halted outputs)
//
// Optional feature macro: IFU_FETCH_COUNT_EN
//   When defined, bus.fetch_count (16 bits) counts normal-fetch edges,
//   saturating at 16'hFFFF.
//
// State table:
//   state | meaning
//   RUN   | fetching; redirect > stall > normal fetch
//   HALT  | halt word fetched; presented once, then frozen until reset
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                   ADDR_W    = 10,
    parameter int                   INSTR_W   = 10,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0]   HALT_WORD = 10'b0010000010,
    parameter logic [3:0]           JUMP_OP   = 4'b1000
) (
    input  logic                    clk,
    input  logic                    reset,
    instr_fetch_unit_if.master      bus
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [ADDR_W-1:0]  pc, pc_n;
    logic [INSTR_W-1:0] instr_q, instr_n;
    logic [ADDR_W-1:0]  instr_pc_q, instr_pc_n;
    logic               valid_q, valid_n;
    logic               halted_q, halted_n;

    logic               is_halt;
    logic               is_jump;
    logic [ADDR_W-1:0]  jump_target;
    logic               fetch_fire;

    assign bus.rom_addr    = pc;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = valid_q;
    assign bus.halted      = halted_q;

    assign is_halt     = (bus.rom_data == HALT_WORD);
    assign is_jump     = (bus.rom_data[INSTR_W-1 -: 4] == JUMP_OP);
    assign jump_target = {{(ADDR_W-6){1'b0}}, bus.rom_data[5:0]};

    // A normal fetch happens only in RUN with neither redirect nor stall.
    assign fetch_fire  = (state == RUN) && !bus.redirect_valid && !bus.stall;

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr_q;
        instr_pc_n = instr_pc_q;
        valid_n    = valid_q;
        halted_n   = halted_q;

        case (state)
            RUN: begin
                if (bus.redirect_valid) begin
                    // Flush: the held instr/instr_pc are no longer valid.
                    pc_n    = bus.redirect_pc;
                    valid_n = 1'b0;
                end else if (!bus.stall) begin
                    instr_n    = bus.rom_data;
                    instr_pc_n = pc;
                    valid_n    = 1'b1;
                    if (is_halt) begin
                        state_n = HALT;
                    end else if (is_jump) begin
                        pc_n = jump_target;
                    end else begin
                        pc_n = pc + ADDR_W'(1);
                    end
                end
            end
            HALT: begin
                // Halt word has been presented for one cycle; freeze.
                valid_n  = 1'b0;
                halted_n = 1'b1;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            pc         <= RESET_PC;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            instr_q    <= instr_n;
            instr_pc_q <= instr_pc_n;
            valid_q    <= valid_n;
            halted_q   <= halted_n;
        end
    end

`ifdef IFU_FETCH_COUNT_EN
    logic [15:0] fetch_count_q, fetch_count_n;

    assign bus.fetch_count = fetch_count_q;

    always_comb begin
        fetch_count_n = fetch_count_q;
        if (fetch_fire && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_n = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_n;
        end
    end
`else
    // Without the counter, fetch_fire has no consumer.
    logic unused_fetch_fire;
    assign unused_fetch_fire = fetch_fire;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam logic [9:0] HALT_W = 10'b0010000010;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    logic [9:0] rom [0:1023];

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(10), .INSTR_W(10)) bus ();

    instr_fetch_unit u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom[i] = 10'h000;
        rom[0]    = 10'h001;
        rom[1]    = 10'h350;
        rom[2]    = 10'h000;
        rom[3]    = 10'h359;
        rom[6]    = 10'b1000001100;
        rom[33]   = HALT_W;
        rom[1023] = 10'h000;

        reset              = 1'b1;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick();
        tick();
        check("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_halted", 32'(bus.halted), 32'd0);
        check("rst_instr", 32'(bus.instr), 32'd0);
        check("rst_instr_pc", 32'(bus.instr_pc), 32'd0);

        // Sequential fetch 0..4
        reset = 1'b0;
        tick();
        check("seq0_pc", 32'(bus.instr_pc), 32'd0);
        check("seq0_instr", 32'(bus.instr), 32'h001);
        check("seq0_valid", 32'(bus.instr_valid), 32'd1);
        tick();
        check("seq1_pc", 32'(bus.instr_pc), 32'd1);
        check("seq1_instr", 32'(bus.instr), 32'h350);
        tick();
        check("seq2_pc", 32'(bus.instr_pc), 32'd2);
        check("seq2_instr", 32'(bus.instr), 32'h000);
        tick();
        check("seq3_pc", 32'(bus.instr_pc), 32'd3);
        check("seq3_instr", 32'(bus.instr), 32'h359);
        check("seq3_valid", 32'(bus.instr_valid), 32'd1);
        tick();
        check("seq4_pc", 32'(bus.instr_pc), 32'd4);
        check("seq4_rom_addr", 32'(bus.rom_addr), 32'd5);

        // Stall three cycles at pc=5
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rom_addr", 32'(bus.rom_addr), 32'd5);
            check("stall_instr_pc", 32'(bus.instr_pc), 32'd4);
            check("stall_instr", 32'(bus.instr), 32'h000);
            check("stall_valid", 32'(bus.instr_valid), 32'd1);
        end

        // Redirect to 16 while stalled
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'd16;
        tick();
        check("redir_rom_addr", 32'(bus.rom_addr), 32'd16);
        check("redir_valid", 32'(bus.instr_valid), 32'd0);
        check("redir_instr_pc_hold", 32'(bus.instr_pc), 32'd4);
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        tick();
        check("redir_next_pc", 32'(bus.instr_pc), 32'd16);
        check("redir_next_valid", 32'(bus.instr_valid), 32'd1);
        check("redir_next_rom_addr", 32'(bus.rom_addr), 32'd17);

        // Jump fold at address 6 -> 12
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'd6;
        tick();
        check("to6_rom_addr", 32'(bus.rom_addr), 32'd6);
        bus.redirect_valid = 1'b0;
        tick();
        check("jmp_instr_pc", 32'(bus.instr_pc), 32'd6);
        check("jmp_instr", 32'(bus.instr), 32'b1000001100);
        check("jmp_valid", 32'(bus.instr_valid), 32'd1);
        check("jmp_rom_addr", 32'(bus.rom_addr), 32'd12);
        tick();
        check("jmp_tgt_pc", 32'(bus.instr_pc), 32'd12);
        check("jmp_tgt_rom_addr", 32'(bus.rom_addr), 32'd13);

        // Run 13..32 sequentially toward the halt word
        for (int k = 13; k <= 32; k++) begin
            tick();
            check("run_instr_pc", 32'(bus.instr_pc), 32'(k));
        end
        check("pre_halt_rom_addr", 32'(bus.rom_addr), 32'd33);

        // Halt word at 33
        tick();
        check("halt_instr", 32'(bus.instr), 32'(HALT_W));
        check("halt_valid", 32'(bus.instr_valid), 32'd1);
        check("halt_instr_pc", 32'(bus.instr_pc), 32'd33);
        check("halt_halted0", 32'(bus.halted), 32'd0);
        check("halt_rom_addr", 32'(bus.rom_addr), 32'd33);
        tick();
        check("halted_valid", 32'(bus.instr_valid), 32'd0);
        check("halted_flag", 32'(bus.halted), 32'd1);
        check("halted_rom_addr", 32'(bus.rom_addr), 32'd33);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'd0;
        tick();
        tick();
        check("halted_ign_redir_addr", 32'(bus.rom_addr), 32'd33);
        check("halted_ign_redir_flag", 32'(bus.halted), 32'd1);
        check("halted_ign_redir_valid", 32'(bus.instr_valid), 32'd0);
        check("halted_instr_frozen", 32'(bus.instr), 32'(HALT_W));
        bus.redirect_valid = 1'b0;

        // Reset while halted
        reset = 1'b1;
        tick();
        check("rst_halt_flag", 32'(bus.halted), 32'd0);
        check("rst_halt_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_halt_valid", 32'(bus.instr_valid), 32'd0);
        reset = 1'b0;

        // Wrap from 1023
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'd1023;
        tick();
        check("wrap_rom_addr_1023", 32'(bus.rom_addr), 32'd1023);
        bus.redirect_valid = 1'b0;
        tick();
        check("wrap_instr_pc", 32'(bus.instr_pc), 32'd1023);
        check("wrap_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("wrap_valid", 32'(bus.instr_valid), 32'd1);

        // Redirect wins over a halt word at rom_data
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'd33;
        tick();
        bus.redirect_pc    = 10'd40;
        tick();
        check("redir_vs_halt_addr", 32'(bus.rom_addr), 32'd40);
        check("redir_vs_halt_flag", 32'(bus.halted), 32'd0);
        bus.redirect_valid = 1'b0;
        tick();
        check("redir_vs_halt_pc", 32'(bus.instr_pc), 32'd40);
        check("redir_vs_halt_run", 32'(bus.rom_addr), 32'd41);
        tick();
        check("redir_vs_halt_nohalt", 32'(bus.halted), 32'd0);

        // Reset mid-stall
        bus.stall = 1'b1;
        reset     = 1'b1;
        tick();
        check("rst_stall_rom_addr", 32'(bus.rom_addr), 32'd0);
        check("rst_stall_valid", 32'(bus.instr_valid), 32'd0);
        reset     = 1'b0;
        bus.stall = 1'b0;
        tick();
        check("rst_stall_first", 32'(bus.instr_pc), 32'd0);
        check("rst_stall_instr", 32'(bus.instr), 32'h001);

`ifdef IFU_FETCH_COUNT_EN
        reset = 1'b1;
        tick();
        check("cnt_reset", 32'(bus.fetch_count), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        bus.stall = 1'b1;
        tick();
        tick();
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 10'd0;
        tick();
        bus.redirect_valid = 1'b0;
        check("cnt_value", 32'(bus.fetch_count), 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Initiator side of the 10-bit instruction ROM interface: owns the program counter, drives the ROM address, and captures the returned word into a registered instruction slot for decode/execute.
- Folds unconditional jumps (opcode 4'b1000) locally.
- Accepts branch redirects from execute.
- Detects the halt word and freezes fetch.

Parameters:
- ADDR_W, 10, ROM address width / PC width
- INSTR_W, 10, instruction width
- RESET_PC, 0, PC value after reset
- HALT_WORD, 10'b0010000010, encoding that stops fetch
- JUMP_OP, 4'b1000, opcode in instr[9:6] for a direct jump; target = zero-extended instr[5:0]

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- rom_addr  out  ADDR_W  address to ROM; ROM returns data combinationally in the same cycle
- rom_data  in  INSTR_W  instruction word from ROM
- stall  in  1  hold all fetch state this cycle
- redirect_valid  in  1  branch taken in execute
- redirect_pc  in  ADDR_W  branch target
- instr  out  INSTR_W  registered fetched instruction
- instr_pc  out  ADDR_W  address instr was fetched from
- instr_valid  out  1  instr is valid for decode this cycle
- halted  out  1  halt word fetched; fetch frozen

Behaviour:
- rom_addr = pc, combinational from the PC register at all times.
- Reset (sampled on a clk edge while reset=1):
  - pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, halted=0, state=RUN.
  - Reset overrides every other input, including in HALT.
- States: RUN, HALT.
- RUN priority per edge: redirect_valid > stall > normal fetch.
- Redirect:
  - pc <= redirect_pc.
  - instr_valid <= 0 (flush); instr and instr_pc hold.
  - Applies even when stall=1.
- Stall (no redirect): pc, instr, instr_pc and instr_valid all hold.
- Normal fetch:
  - instr <= rom_data, instr_pc <= pc, instr_valid <= 1.
  - Next pc:
    - rom_data == HALT_WORD: pc holds, state <= HALT.
    - rom_data[9:6] == JUMP_OP: pc <= {4'b0, rom_data[5:0]}.
    - Otherwise: pc <= pc+1, modulo 2^ADDR_W (1023 wraps to 0).
  - A jump word is still presented on instr with instr_valid=1; downstream treats it as a no-op.
- Latency: a word at address A appears on instr one cycle after pc==A with no stall.
- HALT:
  - On the first HALT cycle, instr_valid=1 carrying HALT_WORD (presented once).
  - On the next edge instr_valid <= 0 and halted <= 1.
  - Thereafter pc, instr and instr_pc are frozen.
  - redirect_valid and stall are ignored; only reset exits.
- Simultaneous redirect and halt word at rom_data: redirect wins; the halt word is discarded and state stays RUN.
- Reset mid-stall or mid-redirect: reset values apply on that edge; the next fetch is at RESET_PC.

Optional Feature:
- Macro: IFU_FETCH_COUNT_EN.
- When defined:
  - Extra port fetch_count, out, 16 bits.
  - Increments by 1 on each normal-fetch edge, including jump and halt words.
  - Does not increment on stalled, redirected or HALT cycles.
  - Saturates at 16'hFFFF; reset value 0.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Sequential fetch: ROM[0..3] = 10'h001, 10'h350, 10'h000, 10'h359; release reset, no stall.
  -> instr_pc = 0, 1, 2, 3 on successive cycles, instr matches each word, instr_valid=1 from the 2nd cycle after reset release.
- Jump fold: ROM[6] = 10'b1000001100.
  -> the cycle after pc=6 fetches, rom_addr=12; instr_pc sequence ...6, 12; address 7 is never fetched.
- Stall and redirect:
  - stall=1 for 3 cycles at pc=5 -> instr and instr_pc frozen, rom_addr=5 throughout.
  - Then redirect_valid=1 with redirect_pc=16 while stall=1 -> next cycle rom_addr=16, instr_valid=0.
  - Following cycle -> instr_pc=16.
- Halt: ROM[33] = HALT_WORD.
  -> instr=10'b0010000010 with instr_valid=1 for one cycle; then halted=1, instr_valid=0.
  -> redirect_valid=1 with redirect_pc=0 afterward has no effect; rom_addr stays 33.
- Wrap and reset:
  - Redirect to 1023 with ROM[1023]=0 -> next rom_addr=0.
  - Assert reset for 1 cycle while halted -> halted=0, rom_addr=0, instr_valid=0.
- With IFU_FETCH_COUNT_EN: run ROM 0..3, stall 2 cycles, redirect once -> fetch_count=4.
